// File: rtl/axis_sa_sched.sv
// Per-command sequencer for the systolic array: joins the X/K streams into the
// array's s_valid/s_last handshake, frames tiles, bounds tiles in flight and detects job completion.
module axis_sa_sched #(
    parameter int WKD          = 16,
    parameter int WT           = 16,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [WKD-1:0] cmd_k,
    input  logic [WT-1:0]  cmd_t,
    input  logic           sx_valid,
    output logic           sx_ready,
    input  logic           sk_valid,
    output logic           sk_ready,
    output logic           sa_s_valid,
    output logic           sa_s_last,
    input  logic           sa_s_ready,
    input  logic           sa_m_valid,
    input  logic           sa_m_last,
    input  logic           sa_m_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int WI = $clog2(MAX_INFLIGHT + 1);
    localparam logic [WI-1:0] CAP = WI'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [WKD-1:0] k_len, beat_cnt;
    logic [WT-1:0]  t_len, tile_cnt;
    logic [WT:0]    out_cnt;
    logic [WI-1:0]  inflight;
    logic           go, acc, issue_last, tile_out, tile_ok, cmd_acc, job_end;

    // Valid never looks at sa_s_ready; each ready looks only at the other stream's valid.
    always_comb begin
        go         = (state == RUN) && (inflight < CAP);
        sa_s_valid = go && sx_valid && sk_valid;
        sa_s_last  = sa_s_valid && (beat_cnt == k_len);
        sx_ready   = go && sk_valid && sa_s_ready;
        sk_ready   = go && sx_valid && sa_s_ready;
        acc        = sa_s_valid && sa_s_ready;
        issue_last = acc && sa_s_last;
        tile_out   = sa_m_valid && sa_m_ready && sa_m_last;
        tile_ok    = tile_out && (inflight != '0);
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        cmd_acc    = cmd_valid && cmd_ready;
        job_end    = (state == DRAIN) && (out_cnt == ({1'b0, t_len} + (WT+1)'(1)));
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_acc) state_nxt = RUN;
            RUN:     if (issue_last && (tile_cnt == t_len)) state_nxt = DRAIN;
            DRAIN:   if (job_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            k_len    <= '0;
            t_len    <= '0;
            beat_cnt <= '0;
            tile_cnt <= '0;
            out_cnt  <= '0;
            inflight <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= job_end;

            if (cmd_acc) begin
                k_len    <= cmd_k;
                t_len    <= cmd_t;
                beat_cnt <= '0;
                tile_cnt <= '0;
            end else if (acc) begin
                if (sa_s_last) begin
                    beat_cnt <= '0;
                    tile_cnt <= tile_cnt + WT'(1);
                end else begin
                    beat_cnt <= beat_cnt + WKD'(1);
                end
            end

            if (cmd_acc)      out_cnt <= '0;
            else if (tile_ok) out_cnt <= out_cnt + (WT+1)'(1);

            // A result tile with nothing outstanding is flagged, not counted.
            if (issue_last && !tile_ok)      inflight <= inflight + WI'(1);
            else if (!issue_last && tile_ok) inflight <= inflight - WI'(1);

            if (tile_out && (inflight == '0)) err <= 1'b1;
        end
    end

endmodule
